// File: rtl/fp_cmp_pipe_if.sv
// Operand/result bus for fp_cmp_pipe.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; a producer holds valid and its payload steady until that edge,
// and ready may depend combinationally on the downstream ready.
interface fp_cmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic             in_valid;
    logic             in_ready;
    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_man;
    logic             b_sign;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] b_man;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out1;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, op, out_ready,
        input  in_ready, out_valid, out1
    );

    // The comparator itself.
    modport slave (
        input  in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, op, out_ready,
        output in_ready, out_valid, out1
    );
endinterface

// File: rtl/fp_cmp_pipe.sv
// Pipelined IEEE-754 style comparator (LT, LE, EQ, UN) with NV flag,
// elastic valid/ready pipeline of PIPE stages and a saturating NV counter.
// Optional build macro: FP_CMP_DENORM_FLUSH_EN flushes subnormal operands to
// signed zero before the ordered compare (NaN detection is unaffected).
module fp_cmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_cmp_pipe_if.slave     bus,
    input  logic             nv_clr,
    output logic [CNT_W-1:0] nv_cnt
);
    localparam int MAG_W = EXP_W + MAN_W;

    localparam logic [1:0] OP_LT = 2'b00;
    localparam logic [1:0] OP_LE = 2'b01;
    localparam logic [1:0] OP_EQ = 2'b10;

    logic             a_nan, b_nan, any_nan, any_snan;
    logic [MAG_W-1:0] a_mag, b_mag;
    logic             both_zero, ord_eq, ord_lt;
    logic [1:0]       res_in;

    logic [PIPE-1:0]  vld;
    logic [1:0]       pay [PIPE];
    logic [PIPE-1:0]  load;
    logic             full;

    // Classify operands and evaluate the selected predicate on the raw inputs.
    always_comb begin
        a_nan    = (&bus.a_exp) && (|bus.a_man);
        b_nan    = (&bus.b_exp) && (|bus.b_man);
        any_nan  = a_nan || b_nan;
        any_snan = (a_nan && !bus.a_man[MAN_W-1]) || (b_nan && !bus.b_man[MAN_W-1]);
`ifdef FP_CMP_DENORM_FLUSH_EN
        a_mag = (bus.a_exp == '0) ? '0 : {bus.a_exp, bus.a_man};
        b_mag = (bus.b_exp == '0) ? '0 : {bus.b_exp, bus.b_man};
`else
        a_mag = {bus.a_exp, bus.a_man};
        b_mag = {bus.b_exp, bus.b_man};
`endif
        // +0 and -0 are equal; otherwise sign-magnitude ordering.
        both_zero = (a_mag == '0) && (b_mag == '0);
        ord_eq    = both_zero || ((bus.a_sign == bus.b_sign) && (a_mag == b_mag));
        if (both_zero) begin
            ord_lt = 1'b0;
        end else if (bus.a_sign != bus.b_sign) begin
            ord_lt = bus.a_sign;
        end else if (bus.a_sign) begin
            ord_lt = a_mag > b_mag;
        end else begin
            ord_lt = a_mag < b_mag;
        end
        // res_in = {nv, result}
        case (bus.op)
            OP_LT:   res_in = {any_nan,  !any_nan && ord_lt};
            OP_LE:   res_in = {any_nan,  !any_nan && (ord_lt || ord_eq)};
            OP_EQ:   res_in = {any_snan, !any_nan && ord_eq};
            default: res_in = {any_snan, any_nan};
        endcase
    end

    // Stage k may load when any stage from k to the output has a hole or the
    // output is draining; built from a running AND to avoid a self-loop.
    always_comb begin
        full = 1'b1;
        load = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            full    = full & vld[k];
            load[k] = bus.out_ready | !full;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld[PIPE-1];
    assign bus.out1      = pay[PIPE-1];

    // Advance valid bits and payloads through the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pay[k] <= 2'b00;
            end
        end else begin
            if (load[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    pay[0] <= res_in;
                end
            end
            for (int k = 1; k < PIPE; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        pay[k] <= pay[k-1];
                    end
                end
            end
        end
    end

    // Count delivered NV results, saturating; a clear overrides an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nv_cnt <= '0;
        end else if (nv_clr) begin
            nv_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out1[1] && !(&nv_cnt)) begin
            nv_cnt <= nv_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Directed bench for fp_cmp_pipe (EXP_W=8, MAN_W=23, PIPE=2, CNT_W=3 so that
// counter saturation is reachable quickly).
module tb_fp_cmp_pipe;
    localparam int CNT_W = 3;
    localparam logic [1:0] LT = 2'b00;
    localparam logic [1:0] LE = 2'b01;
    localparam logic [1:0] EQ = 2'b10;
    localparam logic [1:0] UN = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             nv_clr;
    logic [CNT_W-1:0] nv_cnt;

    int errors = 0;
    int checks = 0;
    int exp_nv = 0;
    logic [1:0] exp_q[$];

    fp_cmp_pipe_if #(.EXP_W(8), .MAN_W(23)) ifc ();

    fp_cmp_pipe #(.EXP_W(8), .MAN_W(23), .PIPE(2), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (ifc),
        .nv_clr (nv_clr),
        .nv_cnt (nv_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: place one operand pair on the bus.
    task automatic drive_operands(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc);
        ifc.a_sign = a[31];
        ifc.a_exp  = a[30:23];
        ifc.a_man  = a[22:0];
        ifc.b_sign = b[31];
        ifc.b_exp  = b[30:23];
        ifc.b_man  = b[22:0];
        ifc.op     = opc;
    endtask

    // Driver: one operation into an empty pipe with out_ready=1. Returns the
    // result and the cycle count until out_valid (-1 on timeout). Optionally
    // pulses nv_clr in the cycle the result is delivered.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc,
                         input bit clr, output logic [1:0] res, output int lat);
        @(negedge clk);
        drive_operands(a, b, opc);
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        lat = -1;
        res = 2'b00;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifc.in_valid = 1'b0;
            if (ifc.out_valid) begin
                lat    = n;
                res    = ifc.out1;
                nv_clr = clr;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        nv_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        checks++;
        if (ifc.out1 !== 2'b00) begin errors++; $display("FAIL reset_out1: got %b want 00", ifc.out1); end
        checks++;
        if (nv_cnt !== '0) begin errors++; $display("FAIL reset_nv_cnt: got %0d want 0", nv_cnt); end
        checks++;
        if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    endtask

    task automatic test_ordered();
        logic [1:0] r;
        int lat;
        do_op(32'h3F800000, 32'h40000000, LT, 1'b0, r, lat);
        checks++;
        if (r !== 2'b01 || lat != 2) begin errors++; $display("FAIL lt_1_2: got %b lat %0d want 01 lat 2", r, lat); end
        do_op(32'h40000000, 32'h3F800000, LT, 1'b0, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 2) begin errors++; $display("FAIL lt_2_1: got %b lat %0d want 00 lat 2", r, lat); end
        do_op(32'hC0000000, 32'hBF800000, LT, 1'b0, r, lat);
        checks++;
        if (r !== 2'b01 || lat != 2) begin errors++; $display("FAIL lt_neg: got %b lat %0d want 01 lat 2", r, lat); end
    endtask

    task automatic test_signed_zero();
        logic [1:0] r;
        int lat;
        do_op(32'h00000000, 32'h80000000, LE, 1'b0, r, lat);
        checks++;
        if (r !== 2'b01 || lat != 2) begin errors++; $display("FAIL zero_le: got %b lat %0d want 01 lat 2", r, lat); end
        do_op(32'h00000000, 32'h80000000, LT, 1'b0, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 2) begin errors++; $display("FAIL zero_lt: got %b lat %0d want 00 lat 2", r, lat); end
        do_op(32'h00000000, 32'h80000000, EQ, 1'b0, r, lat);
        checks++;
        if (r !== 2'b01 || lat != 2) begin errors++; $display("FAIL zero_eq: got %b lat %0d want 01 lat 2", r, lat); end
        do_op(32'h00000000, 32'h80000000, UN, 1'b0, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 2) begin errors++; $display("FAIL zero_un: got %b lat %0d want 00 lat 2", r, lat); end
    endtask

    task automatic test_nan();
        logic [1:0] r;
        int lat;
        do_op(32'h7FC00000, 32'h3F800000, LT, 1'b0, r, lat);
        exp_nv = 1;
        checks++;
        if (r !== 2'b10 || lat != 2) begin errors++; $display("FAIL qnan_lt: got %b lat %0d want 10 lat 2", r, lat); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL qnan_lt_cnt: got %0d want %0d", nv_cnt, exp_nv); end
        do_op(32'h7FC00000, 32'h3F800000, EQ, 1'b0, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 2) begin errors++; $display("FAIL qnan_eq: got %b lat %0d want 00 lat 2", r, lat); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL qnan_eq_cnt: got %0d want %0d", nv_cnt, exp_nv); end
        do_op(32'h7F800001, 32'h3F800000, UN, 1'b0, r, lat);
        exp_nv = 2;
        checks++;
        if (r !== 2'b11 || lat != 2) begin errors++; $display("FAIL snan_un: got %b lat %0d want 11 lat 2", r, lat); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL snan_un_cnt: got %0d want %0d", nv_cnt, exp_nv); end
        do_op(32'h7FC00000, 32'h3F800000, LE, 1'b1, r, lat);
        exp_nv = 0;
        checks++;
        if (r !== 2'b10 || lat != 2) begin errors++; $display("FAIL clr_le: got %b lat %0d want 10 lat 2", r, lat); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL clr_cnt: got %0d want %0d", nv_cnt, exp_nv); end
    endtask

    task automatic test_subnormal();
        logic [1:0] r;
        int lat;
        logic [1:0] exp_lt, exp_eq;
`ifdef FP_CMP_DENORM_FLUSH_EN
        exp_lt = 2'b00;
        exp_eq = 2'b01;
`else
        exp_lt = 2'b01;
        exp_eq = 2'b00;
`endif
        do_op(32'h00000001, 32'h00000002, LT, 1'b0, r, lat);
        checks++;
        if (r !== exp_lt || lat != 2) begin errors++; $display("FAIL denorm_lt: got %b lat %0d want %b lat 2", r, lat, exp_lt); end
        do_op(32'h80000001, 32'h00000000, EQ, 1'b0, r, lat);
        checks++;
        if (r !== exp_eq || lat != 2) begin errors++; $display("FAIL denorm_eq: got %b lat %0d want %b lat 2", r, lat, exp_eq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [1:0]  vo[6];
        logic [1:0]  ve[6];
        logic [1:0]  e;
        logic        rdy, ov;
        logic [1:0]  o1;
        int sent, got, first, last;
        va = '{32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h7F800001, 32'hC0000000, 32'hBF800000};
        vb = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hC0000000};
        vo = '{LT, LT, LT, UN, LT, LT};
        ve = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(ve[i]);
        sent = 0; got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            ifc.out_ready = (cyc >= 4);
            if (sent < 6) begin
                drive_operands(va[sent], vb[sent], vo[sent]);
                ifc.in_valid = 1'b1;
            end else begin
                ifc.in_valid = 1'b0;
            end
            #1;
            rdy = ifc.in_ready;
            ov  = ifc.out_valid;
            o1  = ifc.out1;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (rdy !== 1'b0 || sent != 2) begin errors++; $display("FAIL full_stall c%0d: in_ready %b sent %0d want 0 sent 2", cyc, rdy, sent); end
                checks++;
                if (ov !== 1'b1 || o1 !== 2'b01) begin errors++; $display("FAIL held_out c%0d: valid %b out1 %b want 1 01", cyc, ov, o1); end
            end
            if (cyc == 4) begin
                checks++;
                if (rdy !== 1'b1) begin errors++; $display("FAIL ready_release: in_ready %b want 1", rdy); end
            end
            if (ov && ifc.out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (o1 !== e) begin errors++; $display("FAIL b2b_result %0d: got %b want %b", got, o1, e); end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk);
            if (ifc.in_valid && rdy) sent++;
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        exp_nv = exp_nv + 2;
        checks++;
        if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got); end
        checks++;
        if (last - first != 5) begin errors++; $display("FAIL b2b_span: first %0d last %0d want span 5", first, last); end
        checks++;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: out_valid %b want 0", ifc.out_valid); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", nv_cnt, exp_nv); end
    endtask

    task automatic test_saturation();
        logic [1:0] r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(32'h7FC00000, 32'h3F800000, LT, 1'b0, r, lat);
            exp_nv = (exp_nv == 7) ? 7 : exp_nv + 1;
            checks++;
            if (r !== 2'b10 || lat != 2) begin errors++; $display("FAIL sat_op %0d: got %b lat %0d want 10 lat 2", i, r, lat); end
        end
        checks++;
        if (nv_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt: got %0d want 7", nv_cnt); end
    endtask

    task automatic test_reset_inflight();
        int stale;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        drive_operands(32'h7FC00000, 32'h3F800000, LT);
        ifc.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_operands(32'h3F800000, 32'h40000000, LT);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b want 1", ifc.out_valid); end
        rst_n = 1'b0;
        #1;
        exp_nv = 0;
        checks++;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", ifc.out_valid); end
        checks++;
        if (nv_cnt !== CNT_W'(exp_nv)) begin errors++; $display("FAIL rst_nv_cnt: got %0d want 0", nv_cnt); end
        checks++;
        if (ifc.out1 !== 2'b00) begin errors++; $display("FAIL rst_out1: got %b want 00", ifc.out1); end
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL stale_result: %0d cycles with out_valid, want 0", stale); end
        checks++;
        if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", ifc.in_ready); end
    endtask

    // Reset, run scenarios, report.
    initial begin
        rst_n         = 1'b0;
        nv_clr        = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        drive_operands(32'h0, 32'h0, LT);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ordered();
        test_signed_zero();
        test_nan();
        test_subnormal();
        test_back_to_back();
        test_saturation();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/fp_cmp_pipe.md
# fp_cmp_pipe

Parametrised, pipelined IEEE-754 floating-point comparator with valid/ready handshake. It is the successor to the fixed single-precision LT/LE compare cells in the SFU cache library. It adds configurable exponent/mantissa width and depth, four compare predicates, NaN/invalid signalling, backpressure, and a saturating invalid-event counter. It sits between operand fetch and the SFU result mux.

## Interface
Parameters:
- `EXP_W`, default 8: exponent field width (2..11).
- `MAN_W`, default 23: mantissa field width (2..52).
- `PIPE`, default 2: pipeline stages, i.e. latency (1..4).
- `CNT_W`, default 16: width of the invalid-event counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts operands this cycle.
- `a_sign` in 1 / `a_exp` in EXP_W / `a_man` in MAN_W: operand A fields.
- `b_sign` in 1 / `b_exp` in EXP_W / `b_man` in MAN_W: operand B fields.
- `op` in 2: predicate. 00 = A<B (LT), 01 = A<=B (LE), 10 = A==B (EQ), 11 = unordered (UN).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out1` out 2: bit0 = predicate result, bit1 = invalid (NV) flag.
- `nv_clr` in 1: synchronous clear of `nv_cnt`.
- `nv_cnt` out CNT_W: saturating count of delivered results with NV=1.

## Operation
- Classification:
  - NaN: exp all ones and man≠0.
  - sNaN: NaN with man[MAN_W-1]=0.
  - Zero: exp=0 and man=0.
  - Infinity compares as an ordinary magnitude.
- Ordered compare uses sign-magnitude ordering. +0 and −0 are equal. For two negatives the magnitude order is reversed.
- LT and LE are signalling predicates. If either operand is a NaN: result 0, NV 1.
- EQ: result 0 if either operand is a NaN. NV is 1 only if either operand is an sNaN.
- UN: result 1 if either operand is a NaN, else 0. NV is 1 only if either operand is an sNaN.
- Pipeline: PIPE stages, each holding a valid bit plus the operand/partial-result payload. The partitioning of logic across stages is free, but the result must appear at the final stage.
  - Stage k loads when it is empty or its contents advance this cycle.
  - Final stage drains when `out_valid & out_ready`.
  - `in_ready` = stage 0 empty or stage 0 advancing. It is combinational from `out_ready` through the chain.
- Transfer rules:
  - An input transfer occurs on `in_valid & in_ready`; an output transfer on `out_valid & out_ready`.
  - `out1` is stable while `out_valid=1` and `out_ready=0`.
- Counter:
  - `nv_cnt` increments on each output transfer with `out1[1]=1`.
  - It saturates at all ones.
  - When `nv_clr` and an increment occur in the same cycle, the clear wins and the counter becomes 0.
- Reset is asynchronous. All stage valid bits, payloads, `out1` and `nv_cnt` go to 0. In-flight operations are discarded, and no `out_valid` is produced for them after reset releases.

## Timing
- Latency is exactly PIPE cycles from input transfer to `out_valid` when `out_ready` is held high.
- Throughput is 1 op/cycle sustained with `out_ready=1`.
- Capacity is PIPE operations. With `out_ready=0`, `in_ready` falls once all PIPE stages are full. It returns high in the same cycle `out_ready` rises.
- Reset values: `out_valid`=0, `out1`=2'b00, `nv_cnt`=0. `in_ready`=1 after `rst_n` deasserts.
- Results are delivered in order, with no loss or duplication under any `in_valid`/`out_ready` pattern.

## Configuration
- `FP_CMP_DENORM_FLUSH_EN` defined: subnormal operands (exp=0, man≠0) are treated as signed zero before comparison, so any subnormal equals ±0.
- `FP_CMP_DENORM_FLUSH_EN` undefined: subnormals compare by exact value.
- NaN detection is unaffected by the macro.

## Test plan
All values below use EXP_W=8, MAN_W=23, PIPE=2.
- Ordered compare: LT A=0x3F800000, B=0x40000000 with `out_ready=1` → `out1`=01 exactly 2 cycles after the input transfer. LT with A and B swapped → 00. LT A=0xC0000000, B=0xBF800000 → 01.
- Signed zero: A=0x00000000, B=0x80000000. LE → 01, LT → 00, EQ → 01, UN → 00.
- NaN handling:
  - LT A=0x7FC00000, B=0x3F800000 → 10, and `nv_cnt` goes 0→1.
  - EQ with the same operands → 00, `nv_cnt` unchanged.
  - UN A=0x7F800001 (sNaN) → 11.
  - Pulse `nv_clr` together with an NV result → `nv_cnt`=0.
- Backpressure: issue 6 back-to-back LT ops and hold `out_ready`=0 for 4 cycles. `in_ready` must drop after 2 ops are accepted. On release, all 6 results must emerge in order, unduplicated, one per cycle.
- Subnormals: LT A=0x00000001, B=0x00000002 → 00 with `FP_CMP_DENORM_FLUSH_EN`, 01 without. EQ A=0x80000001, B=0x00000000 → 01 with the macro, 00 without.
- Reset: assert `rst_n`=0 with 2 ops in flight → `out_valid`=0 and `nv_cnt`=0 immediately. After release, no stale result appears and `in_ready`=1.
